servo_ramp_sequencer: RTL

//  Frame-paced motion sequencer for the 24-channel servo PWM bank. CPU sets per-channel target

---
 rtl/servo_seq_pkg.sv | 23 ++
 rtl/servo_frame_timer.sv | 27 ++
 rtl/servo_ramp_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/servo_seq_pkg.sv
// Shared definitions for the servo ramp sequencer: sweep FSM states,
// slave register map and STATUS bit positions.
package servo_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      WRITE = 2'd2,
      NEXT  = 2'd3
   } seq_state_t;

   localparam logic [5:0] ADDR_CTRL        = 6'd0;
   localparam logic [5:0] ADDR_FRAME_TICKS = 6'd1;
   localparam logic [5:0] ADDR_STATUS      = 6'd2;
   localparam logic [5:0] ADDR_TARGET_BASE = 6'd8;
   localparam logic [5:0] ADDR_STEP_BASE   = 6'd32;

   localparam int ST_BUSY      = 0;
   localparam int ST_AT_TARGET = 1;
   localparam int ST_OVERRUN   = 2;
   localparam int ST_IRQ_PEND  = 3;

endpackage

// File: rtl/servo_frame_timer.sv
// Frame pacing counter: counts 0..frame_ticks-1 while enabled and pulses
// tick on the last count. frame_ticks == 0 never ticks.
module servo_frame_timer #(
   parameter int DW = 32
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          enable,
   input  logic [DW-1:0] frame_ticks,
   output logic          tick
);

   logic [DW-1:0] cnt;

   // >= rather than == so a shrinking frame_ticks cannot strand the counter
   assign tick = enable && (frame_ticks != '0) && (cnt >= frame_ticks - DW'(1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (!enable || tick)
         cnt <= '0;
      else
         cnt <= cnt + DW'(1);
   end

endmodule

// File: rtl/servo_ramp_sequencer.sv
// Frame-paced servo ramp sequencer: slews each channel one step per frame and
// pushes changed widths to the PWM bank. Optional irq under SERVO_SEQ_IRQ_EN.
module servo_ramp_sequencer
   import servo_seq_pkg::*;
#(
   parameter int N_CH      = 24,
   parameter int HIGH_BASE = 26,
   parameter int DW        = 32
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          chipselect,
   input  logic [5:0]    address,
   input  logic          write,
   input  logic [DW-1:0] writedata,
   input  logic          read,
   output logic [DW-1:0] readdata,
   output logic [5:0]    m_address,
   output logic          m_write,
   output logic [DW-1:0] m_writedata,
   input  logic          m_waitrequest,
   output logic          irq,
   output logic [1:0]    dbg_state
);

   localparam int CH_W = 5;

   seq_state_t    state, state_nxt;
   logic          enable, tick, overrun, at_target, sweep_ok, irq_pend;
   logic [DW-1:0] frame_ticks;
   logic [DW-1:0] target  [N_CH];
   logic [DW-1:0] step    [N_CH];
   logic [DW-1:0] current [N_CH];
   logic [CH_W-1:0] ch;
   logic [DW-1:0] cur_c, tgt_c, stp_c, diff_c, nxt_c, rd_mux;
   logic          wr_en, rd_en, status_wr, last_ch, sweep_end;

   assign wr_en     = chipselect && write;
   assign rd_en     = chipselect && read;
   assign status_wr = wr_en && (address == ADDR_STATUS);
   assign last_ch   = (ch == CH_W'(N_CH - 1));
   assign sweep_end = (state == NEXT) && last_ch;
   assign dbg_state = state;

   servo_frame_timer #(.DW(DW)) u_timer (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .frame_ticks (frame_ticks),
      .tick        (tick)
   );

   // Step toward target; diff is taken in the safe direction so it never wraps
   always_comb begin
      cur_c  = current[ch];
      tgt_c  = target[ch];
      stp_c  = step[ch];
      diff_c = (tgt_c >= cur_c) ? (tgt_c - cur_c) : (cur_c - tgt_c);
      if ((stp_c == '0) || (diff_c <= stp_c))
         nxt_c = tgt_c;
      else if (tgt_c > cur_c)
         nxt_c = cur_c + stp_c;
      else
         nxt_c = cur_c - stp_c;
   end

   always_comb begin
      rd_mux = '0;
      if (address == ADDR_CTRL)
         rd_mux[0] = enable;
      else if (address == ADDR_FRAME_TICKS)
         rd_mux = frame_ticks;
      else if (address == ADDR_STATUS)
         rd_mux[3:0] = {irq_pend, overrun, at_target, state != IDLE};
      for (int i = 0; i < N_CH; i++) begin
         if (address == ADDR_TARGET_BASE + 6'(i)) rd_mux = target[i];
         if (address == ADDR_STEP_BASE + 6'(i))   rd_mux = step[i];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Master handshake: m_write with m_address/m_writedata is a valid request held
   // unchanged while m_waitrequest=1; a cycle with m_waitrequest=0 completes it.
   always_comb begin
      state_nxt = state;
      m_write   = (state == WRITE);
      case (state)
         IDLE:    if (tick) state_nxt = CALC;
         CALC:    if (!enable)             state_nxt = IDLE;
                  else if (nxt_c == cur_c) state_nxt = NEXT;
                  else                     state_nxt = WRITE;
         WRITE:   if (!m_waitrequest) state_nxt = NEXT;
         NEXT:    state_nxt = (!enable || last_ch) ? IDLE : CALC;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         enable      <= 1'b0;
         frame_ticks <= '0;
         overrun     <= 1'b0;
         at_target   <= 1'b0;
         sweep_ok    <= 1'b0;
         ch          <= '0;
         readdata    <= '0;
         m_address   <= '0;
         m_writedata <= '0;
         for (int i = 0; i < N_CH; i++) begin
            target[i]  <= '0;
            step[i]    <= '0;
            current[i] <= '0;
         end
      end else begin
         if (wr_en && address == ADDR_CTRL)        enable      <= writedata[0];
         if (wr_en && address == ADDR_FRAME_TICKS) frame_ticks <= writedata;
         for (int i = 0; i < N_CH; i++) begin
            if (wr_en && address == ADDR_TARGET_BASE + 6'(i)) target[i] <= writedata;
            if (wr_en && address == ADDR_STEP_BASE + 6'(i))   step[i]   <= writedata;
         end
         if (tick && state != IDLE)                  overrun <= 1'b1;
         else if (status_wr && writedata[ST_OVERRUN]) overrun <= 1'b0;
         if (rd_en) readdata <= rd_mux;

         case (state)
            IDLE: if (tick) begin
               ch       <= '0;
               sweep_ok <= 1'b1;
            end
            CALC: begin
               if (nxt_c != tgt_c) sweep_ok <= 1'b0;
               if (nxt_c != cur_c) begin
                  m_address   <= 6'(HIGH_BASE) + 6'(ch);
                  m_writedata <= nxt_c;
               end
            end
            WRITE: if (!m_waitrequest) current[ch] <= m_writedata;
            NEXT: begin
               if (last_ch) at_target <= sweep_ok;
               else         ch        <= ch + CH_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef SERVO_SEQ_IRQ_EN
   // Rising at_target across sweeps raises the interrupt; set beats clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         irq_pend <= 1'b0;
      else if (sweep_end && sweep_ok && !at_target)
         irq_pend <= 1'b1;
      else if (status_wr && writedata[ST_IRQ_PEND])
         irq_pend <= 1'b0;
   end
`else
   assign irq_pend = 1'b0;
`endif

   assign irq = irq_pend;

endmodule
